// File: rtl/fft_frame_scheduler.sv
// Frame scheduler sharing one streaming FFT core between two sample channels.
// Round-robin per frame, Avalon-ST sink framing with backpressure, per-frame channel tag FIFO.
module fft_frame_scheduler #(
  parameter int DATA_W    = 12,
  parameter int PTS_W     = 14,
  parameter int MAX_PTS   = 8192,
  parameter int MIN_PTS   = 64,
  parameter int TAG_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_enable,
  input  logic [PTS_W-1:0]  cfg_pts,
  input  logic [1:0]        cfg_inverse,
  input  logic [1:0]        ch_valid,
  input  logic [DATA_W-1:0] ch0_data,
  input  logic [DATA_W-1:0] ch1_data,
  output logic [1:0]        ch_ready,
  input  logic              sink_ready,
  output logic              sink_valid,
  output logic              sink_sop,
  output logic              sink_eop,
  output logic [DATA_W-1:0] sink_real,
  output logic [DATA_W-1:0] sink_imag,
  output logic [1:0]        sink_error,
  output logic              inverse,
  output logic [PTS_W-1:0]  fft_pts,
  input  logic              src_valid,
  input  logic              src_ready,
  input  logic              src_eop,
  output logic              out_chan,
  output logic              out_chan_valid,
  output logic              busy,
  output logic [15:0]       frames_done,
  output logic              err_pts,
  output logic              err_eop,
  output logic [1:0]        dbg_state
);

  // Handshake: a sample moves on ch_valid[n] & ch_ready[n] at a rising edge, a sink
  // word on sink_valid & sink_ready; ready latency 0 on both sides.

  localparam int TAG_AW = $clog2(TAG_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARB    = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t             state, state_next;
  logic               sel;
  logic               last;
  logic [PTS_W-1:0]   count;
  logic [PTS_W-1:0]   pts_m1;
  logic               pts_legal;
  logic               arb_pick;
  logic               arb_ch;
  logic               pts_bad;
  logic               load;
  logic               load_eop;
  logic               sink_xfer;
  logic               eop_xfer;

  logic               tag_mem [TAG_DEPTH];
  logic [TAG_AW-1:0]  wr_ptr;
  logic [TAG_AW-1:0]  rd_ptr;
  logic [TAG_AW:0]    tag_cnt;
  logic               tag_full;
  logic               tag_empty;
  logic               pop_req;
  logic               tag_push;
  logic               tag_pop;

  always_comb begin
    pts_legal = (cfg_pts != '0)
             && ((cfg_pts & (cfg_pts - 1'b1)) == '0)
             && (cfg_pts >= PTS_W'(MIN_PTS))
             && (cfg_pts <= PTS_W'(MAX_PTS));
  end

  assign pts_m1    = fft_pts - 1'b1;
  assign tag_full  = (tag_cnt == (TAG_AW+1)'(TAG_DEPTH));
  assign tag_empty = (tag_cnt == '0);
  assign sink_xfer = sink_valid && sink_ready;
  assign eop_xfer  = sink_xfer && sink_eop;
  assign pop_req   = src_valid && src_ready && src_eop;
  assign tag_push  = arb_pick;
  assign tag_pop   = pop_req && !tag_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    arb_pick   = 1'b0;
    arb_ch     = 1'b0;
    pts_bad    = 1'b0;
    ch_ready   = 2'b00;
    load       = 1'b0;
    load_eop   = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_enable) state_next = S_ARB;
      end
      S_ARB: begin
        if (!cfg_enable) begin
          state_next = S_IDLE;
        end else if (!pts_legal) begin
          pts_bad = 1'b1;
        end else if (!tag_full) begin
          // The channel not served last gets first claim on the core.
          if (ch_valid[!last]) begin
            arb_pick = 1'b1;
            arb_ch   = !last;
          end else if (ch_valid[last]) begin
            arb_pick = 1'b1;
            arb_ch   = last;
          end
          if (arb_pick) state_next = S_STREAM;
        end
      end
      S_STREAM: begin
        ch_ready[sel] = !sink_valid || sink_ready;
        load          = ch_valid[sel] && ch_ready[sel];
        load_eop      = (count == pts_m1);
        if (load && load_eop) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (eop_xfer) state_next = S_ARB;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel         <= 1'b0;
      last        <= 1'b1;
      fft_pts     <= '0;
      inverse     <= 1'b0;
      count       <= '0;
      sink_valid  <= 1'b0;
      sink_sop    <= 1'b0;
      sink_eop    <= 1'b0;
      sink_real   <= '0;
      frames_done <= '0;
      err_pts     <= 1'b0;
      err_eop     <= 1'b0;
    end else begin
      if (arb_pick) begin
        sel     <= arb_ch;
        last    <= arb_ch;
        fft_pts <= cfg_pts;
        inverse <= cfg_inverse[arb_ch];
        count   <= '0;
      end
      // Output register: reload on accept, otherwise empty once the word is taken.
      if (load) begin
        sink_real  <= sel ? ch1_data : ch0_data;
        sink_valid <= 1'b1;
        sink_sop   <= (count == '0);
        sink_eop   <= load_eop;
        count      <= count + 1'b1;
      end else if (sink_xfer) begin
        sink_valid <= 1'b0;
      end
      if (eop_xfer)               frames_done <= frames_done + 16'd1;
      if (pts_bad)                err_pts     <= 1'b1;
      if (pop_req && tag_empty)   err_eop     <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
    end else begin
      if (tag_push) wr_ptr <= wr_ptr + 1'b1;
      if (tag_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({tag_push, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[wr_ptr] <= arb_ch;
  end

  assign out_chan       = !tag_empty && tag_mem[rd_ptr];
  assign out_chan_valid = !tag_empty;
  assign busy           = (state != S_IDLE);
  assign sink_imag      = '0;
  assign sink_error     = 2'b00;
  assign dbg_state      = state;

endmodule

// File: doc/fft_frame_scheduler.md
# fft_frame_scheduler

Frame-level scheduler that shares one streaming FFT core between two sample sources (ch0, ch1). Round-robin arbitration per frame, frame length and direction latched per frame, Avalon-ST framing (sink_valid/sop/eop) generated toward the FFT sink with backpressure, and a per-frame channel tag queue so output frames from the FFT source port can be attributed. Sits between the ADC capture front-ends and the FFT core, replacing the single-channel framing controller.

## Interface
- DATA_W, 12, sample width (real part)
- PTS_W, 14, width of frame-length fields
- MAX_PTS, 8192, largest legal frame length
- MIN_PTS, 64, smallest legal frame length
- TAG_DEPTH, 2, max frames in flight inside the FFT (tag FIFO depth, power of two)

- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- cfg_enable  in  1  allow new frames to start
- cfg_pts  in  PTS_W  requested frame length, sampled at frame start
- cfg_inverse  in  2  per-channel direction (bit n = ch n, 1 = IFFT)
- ch_valid  in  2  per-channel sample valid
- ch0_data, ch1_data  in  DATA_W  samples
- ch_ready  out  2  per-channel sample accept
- sink_ready  in  1  FFT sink ready (ready latency 0)
- sink_valid, sink_sop, sink_eop  out  1  FFT sink framing
- sink_real, sink_imag  out  DATA_W  FFT sink data; imag always 0
- sink_error  out  2  always 2'b00
- inverse  out  1  direction for current frame
- fft_pts  out  PTS_W  length of current frame
- src_valid, src_ready, src_eop  in  1  FFT source-port handshake, observed only
- out_chan  out  1  channel tag of frame currently leaving the FFT (FIFO head)
- out_chan_valid  out  1  tag FIFO non-empty
- busy  out  1  state != IDLE
- frames_done  out  16  count of eop transfers into FFT sink, wraps
- err_pts  out  1  sticky: illegal cfg_pts at a frame start attempt
- err_eop  out  1  sticky: src eop with tag FIFO empty

## Operation
- States: IDLE, ARB, STREAM, DRAIN.
- IDLE: cfg_enable=1 -> ARB.
- ARB: if cfg_enable=0 -> IDLE. Else if cfg_pts illegal (not power of two, < MIN_PTS or > MAX_PTS) -> set err_pts, stay ARB. Else if tag FIFO full -> stay. Else pick requesting channel: the one not served last if its ch_valid=1, else the other if its ch_valid=1, else stay. On pick: sel<=ch, last<=ch, fft_pts<=cfg_pts, inverse<=cfg_inverse[ch], push ch into tag FIFO, count<=0, -> STREAM.
- STREAM: ch_ready[sel] = (!sink_valid || sink_ready); other ch_ready=0. Accepted sample loads output register: sink_real<=data, sink_valid<=1, sink_sop<=(count==0), sink_eop<=(count==fft_pts-1), count++. Output register empties (sink_valid<=0) on transfer with no new load. On loading eop -> DRAIN.
- DRAIN: ch_ready=0; on eop transfer (sink_valid&sink_ready&sink_eop) -> ARB. fft_pts/inverse constant from ARB exit through eop transfer.
- frames_done increments on every sink eop transfer.
- Tag FIFO: pop on src_valid&src_ready&src_eop. Simultaneous push/pop: occupancy unchanged. Pop when empty: ignored, err_eop<=1.
- cfg_enable deasserting mid-frame: current frame completes; return to IDLE from ARB.
- Sample gaps (ch_valid low) mid-frame: stall, no bubble inserted in framing; sink_valid low meanwhile.

## Timing
- Reset values: state IDLE, all outputs 0 except last<=1 (ch0 wins first arbitration); tag FIFO empty; errors cleared; fft_pts=0.
- Reset mid-frame aborts frame at the next edge; FFT core is reset by the same rst_n.
- Input-to-sink latency: 1 cycle (sample accepted at edge N is on sink from N+1).
- Sustained throughput 1 sample/cycle when ch_valid and sink_ready held high.
- Inter-frame gap: eop transfer at edge T -> ARB in T+1, STREAM in T+2, first sample accepted T+2, sop on sink T+3.
- sink_* held stable while sink_valid=1 and sink_ready=0.
- count width PTS_W; compare against fft_pts-1 in PTS_W arithmetic (MAX_PTS=8192 fits 14 bits).

## Test plan
- Single channel, cfg_pts=64, ch_valid[0]=1, sink_ready=1 -> 64 consecutive sink transfers, sop on first, eop on 64th, fft_pts=64, frames_done=1, sop of next frame exactly 3 cycles after eop transfer.
- Both channels requesting, cfg_pts=64, cfg_inverse=2'b10 -> frames alternate ch0,ch1,ch0; inverse=0,1,0; data matches source channel.
- sink_ready toggled randomly at 50% -> no sample lost/duplicated, sink_* stable while stalled, exactly one sop and one eop per 64 transfers.
- TAG_DEPTH=2, no src eop -> third frame held in ARB; single src eop pulse -> third frame starts, out_chan reports ch of oldest frame; src eop with empty FIFO -> err_eop=1.
- cfg_pts=100 then 8192 -> err_pts=1, no sink_valid; after change to 8192, one 8192-sample frame with fft_pts=8192.
- rst_n low for 1 cycle at sample 30 of a frame -> all outputs 0 next cycle, FIFO empty, next frame starts with ch0 and sop.
